// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. A prescaler divides the clock into digit slots. Each slot begins
// with a guard interval during which all anodes are off. New digit values are
// staged on 'load' and only become visible at a frame boundary, so a frame is
// never drawn with a mix of old and new digits.
//
// Optional feature (compile-time macro): LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (digit3..digit1) are suppressed.
//   Digit0 is always shown, so a value of 0000 displays as "0".
//   When undefined, every digit is shown as held, including leading zeros.
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 64,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  an,
  output logic [3:0]  digit_code,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD_CYCLES);
  localparam logic [3:0]       BLANK     = 4'hF;

  // Scan position
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;

  // Digit storage
  logic [15:0] staging_q, staging_d;
  logic [15:0] active_q, active_d;
  logic        pending_q, pending_d;

  // Registered outputs
  logic [3:0] an_q, an_d;
  logic [3:0] code_q, code_d;
  logic [1:0] didx_q, didx_d;
  logic       fd_pend_q;
  logic       frame_done_q;

  // Decoded scan conditions
  logic       last_cnt;
  logic       frame_bnd;
  logic       in_guard;
  logic       lz_blank;
  logic       dark;
  logic [3:0] digit_sel;

  assign last_cnt  = (cnt_q == LAST_CNT);
  assign frame_bnd = enable && (idx_q == 2'd3) && last_cnt;
  assign in_guard  = (cnt_q < GUARD_CNT);
  assign digit_sel = active_q[{idx_q, 2'b00} +: 4];

  // Leading-zero suppression for the slot being scanned, taken from the active value
  always_comb begin
    lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd3:    lz_blank = (active_q[15:12] == 4'h0);
      2'd2:    lz_blank = (active_q[15:8]  == 8'h00);
      2'd1:    lz_blank = (active_q[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
`else
    lz_blank = 1'b0;
`endif
  end

  // Next prescaler count and slot index; disabled scan parks at slot 0, count 0
  always_comb begin
    cnt_d = '0;
    idx_d = 2'd0;
    if (enable) begin
      if (last_cnt) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
      end
    end
  end

  // Staging/active hand-off: boundary transfer uses the old staging value,
  // a coincident load then refills staging and keeps the value pending
  always_comb begin
    staging_d = staging_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (frame_bnd && pending_q) begin
      active_d  = staging_q;
      pending_d = 1'b0;
    end
    if (load) begin
      staging_d = digits_in;
      pending_d = 1'b1;
    end
  end

  // Output decode for the current slot; registered below for one-cycle latency
  always_comb begin
    dark   = !enable || in_guard || blank_mask[idx_q] || lz_blank;
    an_d   = dark ? 4'b1111 : ~(4'b0001 << idx_q);
    code_d = dark ? BLANK : digit_sel;
    didx_d = enable ? idx_q : 2'd0;
  end

  // Scan counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Digit staging, active value and pending flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_q <= 16'h0000;
      active_q  <= 16'h0000;
      pending_q <= 1'b0;
    end else begin
      staging_q <= staging_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  // Output registers; frame_done is delayed one extra stage so it lines up
  // with the output cycle that shows digit_idx wrapping back to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q         <= 4'b1111;
      code_q       <= BLANK;
      didx_q       <= 2'd0;
      fd_pend_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      code_q       <= code_d;
      didx_q       <= didx_d;
      fd_pend_q    <= frame_bnd;
      frame_done_q <= fd_pend_q;
    end
  end

  assign an         = an_q;
  assign digit_code = code_q;
  assign digit_idx  = didx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Testbench for seven_seg_scan_ctrl (REFRESH_DIV=8, GUARD_CYCLES=2).
// Model tracks the scan as a single linear position within a frame.
module tb_seven_seg_scan_ctrl;

  localparam int R = 8;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  an;
  logic [3:0]  digit_code;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  seven_seg_scan_ctrl #(.REFRESH_DIV(R), .GUARD_CYCLES(G), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits_in),
    .load(load), .blank_mask(blank_mask), .an(an), .digit_code(digit_code),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          pos;
  logic [15:0] m_stg, m_act;
  bit          m_pend, bnd_prev;
  logic [3:0]  e_an, e_code;
  logic [1:0]  e_idx;
  bit          e_fd;

  function automatic bit lz(input int s, input logic [15:0] a);
`ifdef LEADING_ZERO_BLANK_EN
    if (s == 0) return 1'b0;
    return (a >> (4 * s)) == 16'h0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int slot, ph;
    bit bnd;
    if (!rst_n) begin
      pos = 0; m_stg = 0; m_act = 0; m_pend = 0; bnd_prev = 0;
      e_an = 4'hF; e_code = 4'hF; e_idx = 0; e_fd = 0;
    end else begin
      slot = pos / R;
      ph = pos % R;
      e_fd = bnd_prev;
      if (!enable) begin
        e_an = 4'hF; e_code = 4'hF; e_idx = 0;
      end else begin
        e_idx = 2'(slot);
        if (ph < G || blank_mask[slot] || lz(slot, m_act)) begin
          e_an = 4'hF; e_code = 4'hF;
        end else begin
          e_an = ~(4'b0001 << slot);
          e_code = m_act[4*slot +: 4];
        end
      end
      bnd = enable && (pos == 4*R - 1);
      bnd_prev = bnd;
      if (bnd && m_pend) begin m_act = m_stg; m_pend = 0; end
      if (load) begin m_stg = digits_in; m_pend = 1; end
      pos = enable ? (pos + 1) % (4*R) : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("an", {12'h0, an}, {12'h0, e_an});
      cmp("digit_code", {12'h0, digit_code}, {12'h0, e_code});
      cmp("digit_idx", {14'h0, digit_idx}, {14'h0, e_idx});
      cmp("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    cmp("wait_frame_done", {15'h0, frame_done}, 16'h1);
  endtask

  // Starting at a frame_done cycle, record the code shown in each lit slot
  task automatic collect(output logic [15:0] shown, output int lit);
    shown = 16'hFFFF;
    lit = 0;
    cmp("collect_start_fd", {15'h0, frame_done}, 16'h1);
    for (int i = 0; i < 4*R; i++) begin
      if (an !== 4'hF) begin
        shown[int'(digit_idx)*4 +: 4] = digit_code;
        lit++;
      end
      tick();
    end
  endtask

  logic [15:0] shown;
  int lit;

  initial begin
    tick();
    chk_en = 1'b1;
    cmp("rst_an", {12'h0, an}, 16'h000F);
    cmp("rst_code", {12'h0, digit_code}, 16'h000F);
    cmp("rst_idx", {14'h0, digit_idx}, 16'h0);
    cmp("rst_fd", {15'h0, frame_done}, 16'h0);

    enable = 1'b1;
    rst_n = 1'b1;

    // Opening timeline; pending load of 1234 mid-frame, then 5678 at the boundary
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (k <= 2 || k == 9 || k == 10) cmp("tl_an_guard", {12'h0, an}, 16'h000F);
      else if (k <= 8) cmp("tl_an_slot0", {12'h0, an}, 16'h000E);
      else if (k <= 16) cmp("tl_an_slot1", {12'h0, an}, 16'h000D);
      if (k == 8) cmp("tl_idx8", {14'h0, digit_idx}, 16'h0);
      if (k == 9) cmp("tl_idx9", {14'h0, digit_idx}, 16'h1);
      if (k <= 40) cmp("tl_fd", {15'h0, frame_done}, {15'h0, (k == 33)});
      if (k > 40 && k <= 64)
        cmp("stale_code", {15'h0, (digit_code == 4'h0 || digit_code == 4'hF)}, 16'h1);
      if (k == 65) cmp("fd_after_load", {15'h0, frame_done}, 16'h1);
      if (k == 40) begin load = 1'b1; digits_in = 16'h1234; end
      else if (k == 63) begin load = 1'b1; digits_in = 16'h5678; end
      else load = 1'b0;
    end
    collect(shown, lit);
    cmp("frame_1234", shown, 16'h1234);
    collect(shown, lit);
    cmp("frame_5678", shown, 16'h5678);

    // Blank mask on slot 2
    digits_in = 16'h1234; load = 1'b1; blank_mask = 4'b0100;
    tick();
    load = 1'b0;
    wait_fd();
    collect(shown, lit);
    cmp("mask_shown", shown, 16'h1F34);
    cmp("mask_lit", 16'(lit), 16'd18);
    blank_mask = 4'b0000;

    // Drop enable during slot 2, then re-enable
    repeat (19) tick();
    cmp("slot2_lit", {12'h0, an}, 16'h000B);
    enable = 1'b0;
    tick();
    cmp("dis_an", {12'h0, an}, 16'h000F);
    cmp("dis_idx", {14'h0, digit_idx}, 16'h0);
    cmp("dis_code", {12'h0, digit_code}, 16'h000F);
    repeat (3) tick();
    enable = 1'b1;
    tick(); cmp("reen_g0", {12'h0, an}, 16'h000F);
    tick(); cmp("reen_g1", {12'h0, an}, 16'h000F);
    tick(); cmp("reen_lit", {12'h0, an}, 16'h000E);

    // Reset mid-scan
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    cmp("mrst_an", {12'h0, an}, 16'h000F);
    cmp("mrst_code", {12'h0, digit_code}, 16'h000F);
    cmp("mrst_idx", {14'h0, digit_idx}, 16'h0);
    cmp("mrst_fd", {15'h0, frame_done}, 16'h0);
    tick(); tick();
    rst_n = 1'b1;

    // Leading zeros
    digits_in = 16'h0040; load = 1'b1;
    tick();
    load = 1'b0;
    wait_fd();
    collect(shown, lit);
`ifdef LEADING_ZERO_BLANK_EN
    cmp("lz_0040", shown, 16'hFF40);
`else
    cmp("lz_0040", shown, 16'h0040);
`endif
    digits_in = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    wait_fd();
    collect(shown, lit);
`ifdef LEADING_ZERO_BLANK_EN
    cmp("lz_0000", shown, 16'hFFF0);
`else
    cmp("lz_0000", shown, 16'h0000);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      load = ($urandom_range(0, 19) == 0);
      digits_in = 16'($urandom);
      if ($urandom_range(0, 99) == 0) blank_mask = 4'($urandom);
      if (i == 1500) rst_n = 1'b0;
      if (i == 1501) rst_n = 1'b1;
    end
    tick();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
